// File: rtl/mul_ctrl_fsm.sv
// Control FSM for the repeated-addition multiplier.
// Drives the datapath strobes from start and the datapath eqz status.
// Reports busy/done/aborted and counts the additions performed.
//
// Handshake: start is sampled only in IDLE. The cycle after an accepted
// start, busy rises and stays high through the last ADD cycle. After that,
// exactly one of done or aborted pulses for a single cycle. An abort seen in
// LOAD_A, LOAD_B or ADD cancels the operation; an abort seen in any other
// state is ignored. All outputs decode the registered state (plus eqz in
// ADD), so start and abort never reach an output combinationally.
module mul_ctrl_fsm #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             eqz,
   output logic             selA,
   output logic             selB,
   output logic             ldA,
   output logic             ldB,
   output logic             decB,
   output logic             ldP,
   output logic             clrP,
   output logic             busy,
   output logic             done,
   output logic             aborted,
   output logic [CNT_W-1:0] iter_cnt,
   output logic [2:0]       state_dbg
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_A = 3'd1,
      LOAD_B = 3'd2,
      ADD    = 3'd3,
      DONE   = 3'd4,
      ABORT  = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t state;
   state_t state_nxt;

   assign state_dbg = state;

   // State register; reset discards any in-flight operation silently.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; abort overrides the normal step in the busy states.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = start ? LOAD_A : IDLE;
         LOAD_A:  state_nxt = abort ? ABORT : LOAD_B;
         LOAD_B:  state_nxt = abort ? ABORT : ADD;
         ADD: begin
            if (abort) begin
               state_nxt = ABORT;
            end else if (eqz) begin
               state_nxt = DONE;
            end else begin
               state_nxt = ADD;
            end
         end
         DONE:    state_nxt = IDLE;
         ABORT:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode; in ADD the add/decrement pair is gated by eqz.
   always_comb begin
      selA    = 1'b0;
      selB    = 1'b0;
      ldA     = 1'b0;
      ldB     = 1'b0;
      decB    = 1'b0;
      ldP     = 1'b0;
      clrP    = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      aborted = 1'b0;
      case (state)
         LOAD_A: begin
            selA = 1'b1;
            ldA  = 1'b1;
            busy = 1'b1;
         end
         LOAD_B: begin
            selB = 1'b1;
            ldB  = 1'b1;
            clrP = 1'b1;
            busy = 1'b1;
         end
         ADD: begin
            busy = 1'b1;
            if (!eqz) begin
               ldP  = 1'b1;
               decB = 1'b1;
            end
         end
         DONE:    done    = 1'b1;
         ABORT:   aborted = 1'b1;
         default: ;
      endcase
   end

   // Iteration counter: cleared in LOAD_A, counts every issued ldP and
   // saturates at all-ones. It holds its value until the next LOAD_A.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         iter_cnt <= '0;
      end else if (state == LOAD_A) begin
         iter_cnt <= '0;
      end else if (ldP && (iter_cnt != CNT_MAX)) begin
         iter_cnt <= iter_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_mul_ctrl_fsm.sv
// Testbench for mul_ctrl_fsm. A small behavioural datapath closes the eqz
// loop. Each operation is checked against A*B and against the cycle timing
// derived from the operand B.
module tb_mul_ctrl_fsm;

   localparam int CNT_W = 16;
   localparam logic [2:0] IDLE_CODE = 3'd0;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic eqz;
   logic selA, selB, ldA, ldB, decB, ldP, clrP, busy, done, aborted;
   logic [CNT_W-1:0] iter_cnt;
   logic [2:0]       state_dbg;

   logic [15:0] ain = '0;
   logic [15:0] bin = '0;
   logic [15:0] a_reg = '0;
   logic [15:0] b_cnt = '0;
   logic [15:0] p_reg = '0;
   logic [15:0] bus;

   int n_checks = 0;
   int n_pass = 0;
   logic [31:0] exp_q[$];

   mul_ctrl_fsm #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .eqz(eqz),
      .selA(selA), .selB(selB), .ldA(ldA), .ldB(ldB), .decB(decB),
      .ldP(ldP), .clrP(clrP), .busy(busy), .done(done), .aborted(aborted),
      .iter_cnt(iter_cnt), .state_dbg(state_dbg)
   );

   // clock
   always #5 clk = ~clk;

   // behavioural datapath driven by the DUT strobes
   assign bus = selA ? ain : (selB ? bin : 16'd0);
   assign eqz = (b_cnt == 16'd0);
   always @(posedge clk) begin
      if (ldA) a_reg <= bus;
      if (ldB) b_cnt <= bus;
      else if (decB) b_cnt <= b_cnt - 16'd1;
      if (clrP) p_reg <= 16'd0;
      else if (ldP) p_reg <= p_reg + a_reg;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   // One multiply of a*b. abort_add=k>0 raises abort during the k-th ADD
   // cycle. noise toggles start randomly while the operation is busy.
   task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                        input int abort_add, input bit noise);
      int n;
      int done_edge, done_cnt, ab_edge, ab_cnt, ldp_cnt, excl_viol, busy_at_done;
      int exp_iter;
      n = int'(b);
      done_edge = 0; done_cnt = 0; ab_edge = 0; ab_cnt = 0;
      ldp_cnt = 0; excl_viol = 0; busy_at_done = 0;
      @(negedge clk);
      ain = a; bin = b; start = 1'b1;
      if (abort_add == 0) exp_q.push_back(32'(a) * 32'(b));
      for (int e = 1; e <= n + 12; e++) begin
         @(negedge clk);
         if (done) begin
            done_cnt++;
            if (done_edge == 0) done_edge = e;
            if (busy) busy_at_done++;
            if (exp_q.size() > 0) check("product", 32'(p_reg), exp_q.pop_front());
            else check("unexpected_done", 32'd1, 32'd0);
         end
         if (aborted) begin
            ab_cnt++;
            if (ab_edge == 0) ab_edge = e;
         end
         if (ldP) ldp_cnt++;
         if ((selA && selB) || (ldP && clrP)) excl_viol++;
         if (noise && abort_add == 0 && e <= n + 3) start = 1'($urandom_range(0, 1));
         else start = 1'b0;
         abort = (abort_add > 0) && (e == 2 + abort_add);
      end
      abort = 1'b0;
      if (abort_add == 0) begin
         check("done_edge", done_edge, n + 4);
         check("done_cnt", done_cnt, 1);
         check("aborted_cnt", ab_cnt, 0);
         check("ldp_cnt", ldp_cnt, n);
         check("iter_cnt", 32'(iter_cnt), n);
      end else begin
         exp_iter = (abort_add <= n) ? abort_add : n;
         check("abort_edge", ab_edge, 3 + abort_add);
         check("aborted_cnt", ab_cnt, 1);
         check("done_cnt_abort", done_cnt, 0);
         check("ldp_cnt_abort", ldp_cnt, exp_iter);
         check("iter_cnt_abort", 32'(iter_cnt), exp_iter);
      end
      check("excl_strobes", excl_viol, 0);
      check("busy_with_done", busy_at_done, 0);
   endtask

   initial begin
      int d1, d2, dcnt, rise2, acnt;
      logic prev_busy;
      logic [15:0] ra, rb;
      int k;

      // reset
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", 32'({selA, selB, ldA, ldB, decB, ldP, clrP, busy, done, aborted}), 32'd0);
      check("reset_iter", 32'(iter_cnt), 32'd0);
      check("reset_state", 32'(state_dbg), 32'(IDLE_CODE));
      rst_n = 1'b1;

      // directed cases
      do_op(16'd5, 16'd3, 0, 1'b0);
      do_op(16'd7, 16'd0, 0, 1'b0);
      do_op(16'd0, 16'd4, 0, 1'b0);
      do_op(16'd9, 16'd10, 2, 1'b0);
      do_op(16'd4, 16'd3, 0, 1'b1);

      // abort ignored in IDLE
      @(negedge clk); abort = 1'b1;
      @(negedge clk); abort = 1'b0;
      check("idle_abort_ignored", 32'({busy, aborted}), 32'd0);

      // start held high: second LOAD_A one cycle after DONE
      @(negedge clk);
      ain = 16'd3; bin = 16'd2; start = 1'b1;
      exp_q.push_back(32'd6); exp_q.push_back(32'd6);
      d1 = 0; d2 = 0; dcnt = 0; rise2 = 0; prev_busy = 1'b0;
      for (int e = 1; e <= 22; e++) begin
         @(negedge clk);
         if (done) begin
            dcnt++;
            if (d1 == 0) d1 = e; else if (d2 == 0) d2 = e;
            if (exp_q.size() > 0) check("held_product", 32'(p_reg), exp_q.pop_front());
            else check("held_extra_done", 32'd1, 32'd0);
         end
         if (busy && !prev_busy && e > 1 && rise2 == 0) rise2 = e;
         prev_busy = busy;
         if (e == 9) start = 1'b0;
      end
      check("held_done1", d1, 6);
      check("held_reload", rise2, 8);
      check("held_done2", d2, 13);
      check("held_done_cnt", dcnt, 2);

      // reset during ADD of 6x50
      @(negedge clk);
      ain = 16'd6; bin = 16'd50; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (8) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("midreset_outputs", 32'({selA, selB, ldA, ldB, decB, ldP, clrP, busy, done, aborted}), 32'd0);
      check("midreset_iter", 32'(iter_cnt), 32'd0);
      check("midreset_state", 32'(state_dbg), 32'(IDLE_CODE));
      dcnt = 0; acnt = 0;
      repeat (60) begin
         @(negedge clk);
         if (done) dcnt++;
         if (aborted || busy) acnt++;
      end
      check("midreset_no_done", dcnt, 0);
      check("midreset_quiet", acnt, 0);
      do_op(16'd6, 16'd2, 0, 1'b0);

      // randomized operations
      for (int i = 0; i < 12; i++) begin
         ra = 16'($urandom_range(0, 255));
         rb = 16'($urandom_range(0, 20));
         k = 0;
         if (rb != 16'd0 && $urandom_range(0, 3) == 0) k = $urandom_range(1, int'(rb) + 1);
         do_op(ra, rb, k, 1'($urandom_range(0, 1)));
      end

      check("queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
